// File: rtl/binary2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// A single bank of add-3 correctors is reused on every shift cycle. Operands
// may be unsigned or two's complement. In the signed case the magnitude is
// converted and the sign is reported on out_neg.
//
// state | meaning
// IDLE  | ready for an operand (in_ready = 1)
// SHIFT | one correct-and-shift step per cycle, counter runs WIDTH -> 0
// DONE  | result held on out_bcd/out_neg, waiting for out_ready

module binary2bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3,
   parameter int SIGNED = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  out_neg
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);
   // Decimal digits of 2^WIDTH-1 = floor(WIDTH*log10(2)) + 1 (2^WIDTH is never a power of ten)
   localparam int MIN_DIGITS = (WIDTH * 30103) / 100000 + 1;

   generate
      if (WIDTH < 2 || DIGITS < MIN_DIGITS) begin : g_param_check
         $error("binary2bcd_seq: WIDTH must be >= 2 and DIGITS must hold 2^WIDTH-1");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   bin_sr;
   logic [WIDTH-1:0]   mag;
   logic [BCD_W-1:0]   bcd_sr;
   logic [BCD_W-1:0]   bcd_adj;
   logic [BCD_W-1:0]   bcd_shift;
   logic [CNT_W-1:0]   cnt;
   logic               neg_pend;
   logic               neg_in;
   logic               accept;
   logic               last_shift;

   // Operand sign and magnitude; the most-negative value maps to 2^(WIDTH-1), which still fits
   always_comb begin
      neg_in = (SIGNED != 0) && in_data[WIDTH-1];
      mag    = in_data;
      if (neg_in) begin
         mag = ~in_data + WIDTH'(1);
      end
   end

   // Handshake and terminal-count decode
   always_comb begin
      accept     = (state == IDLE) && in_valid;
      last_shift = (state == SHIFT) && (cnt == CNT_W'(1));
   end

   // Shared add-3 bank: every digit >= 5 gets +3 (no inter-digit carry), then the shift
   always_comb begin
      bcd_adj = bcd_sr;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd_sr[4*k +: 4] >= 4'd5) begin
            bcd_adj[4*k +: 4] = bcd_sr[4*k +: 4] + 4'd3;
         end
      end
      bcd_shift = {bcd_adj[BCD_W-2:0], bin_sr[WIDTH-1]};
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)   state_nxt = SHIFT;
         SHIFT:   if (last_shift) state_nxt = DONE;
         DONE:    if (out_ready)  state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   // Working shift register, down-counter and pending sign
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_sr   <= '0;
         bcd_sr   <= '0;
         cnt      <= '0;
         neg_pend <= 1'b0;
      end else if (accept) begin
         bin_sr   <= mag;
         bcd_sr   <= '0;
         cnt      <= CNT_W'(WIDTH);
         neg_pend <= neg_in;
      end else if (state == SHIFT) begin
         bin_sr   <= {bin_sr[WIDTH-2:0], 1'b0};
         bcd_sr   <= bcd_shift;
         cnt      <= cnt - CNT_W'(1);
      end
   end

   // Result registers update only on the final shift so they hold between conversions
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_bcd <= '0;
         out_neg <= 1'b0;
      end else if (last_shift) begin
         out_bcd <= bcd_shift;
         out_neg <= neg_pend;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

endmodule

// File: tb/tb_binary2bcd_seq.sv
// Scoreboard bench for binary2bcd_seq: three instances (8-bit unsigned,
// 16-bit unsigned, 8-bit signed). Expected results are pushed when an operand
// is accepted and popped by a monitor when a result is handed off.

module tb_binary2bcd_seq;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [2:0]        iv = '0;
   logic [2:0]        ordy = '1;
   logic [2:0][15:0]  idat = '0;
   logic [2:0]        irdy;
   logic [2:0]        ovld;
   logic [2:0]        oneg;
   logic [2:0][19:0]  obcd;

   logic              irdy_a, irdy_b, irdy_c;
   logic              ovld_a, ovld_b, ovld_c;
   logic              oneg_a, oneg_b, oneg_c;
   logic [11:0]       bcd_a;
   logic [19:0]       bcd_b;
   logic [11:0]       bcd_c;

   int                W [3] = '{8, 16, 8};
   int                S [3] = '{0, 0, 1};

   int                n_vec = 0;
   int                n_err = 0;
   int                cyc = 0;
   int                acc_cyc [3] = '{0, 0, 0};
   bit                busy [3] = '{0, 0, 0};
   bit                ovld_q [3] = '{0, 0, 0};
   bit                rnd_mode = 0;

   logic [20:0]       q0 [$];
   logic [20:0]       q1 [$];
   logic [20:0]       q2 [$];

   always #5 clk = ~clk;

   binary2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) u_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[0]), .in_ready(irdy_a), .in_data(idat[0][7:0]),
      .out_valid(ovld_a), .out_ready(ordy[0]), .out_bcd(bcd_a), .out_neg(oneg_a)
   );

   binary2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[1]), .in_ready(irdy_b), .in_data(idat[1]),
      .out_valid(ovld_b), .out_ready(ordy[1]), .out_bcd(bcd_b), .out_neg(oneg_b)
   );

   binary2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u_c (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[2]), .in_ready(irdy_c), .in_data(idat[2][7:0]),
      .out_valid(ovld_c), .out_ready(ordy[2]), .out_bcd(bcd_c), .out_neg(oneg_c)
   );

   assign irdy = {irdy_c, irdy_b, irdy_a};
   assign ovld = {ovld_c, ovld_b, ovld_a};
   assign oneg = {oneg_c, oneg_b, oneg_a};
   assign obcd = {20'(bcd_c), bcd_b, 20'(bcd_a)};

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: magnitude and sign by plain arithmetic, digits by repeated /10
   function automatic logic [20:0] model(int i, logic [15:0] d);
      longint     mag;
      longint     full;
      bit         neg;
      logic [19:0] b;
      full = longint'(1) << W[i];
      mag  = longint'(d) % full;
      neg  = 1'b0;
      if (S[i] != 0 && mag >= full / 2) begin
         neg = 1'b1;
         mag = full - mag;
      end
      b = '0;
      for (int k = 0; k < 5; k++) begin
         b[4*k +: 4] = 4'(mag % 10);
         mag = mag / 10;
      end
      return {neg, b};
   endfunction

   function automatic void qpush(int i, logic [20:0] v);
      case (i)
         0: q0.push_back(v);
         1: q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endfunction

   function automatic logic [20:0] qpop(int i);
      case (i)
         0: return q0.pop_front();
         1: return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   function automatic int qsize(int i);
      case (i)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d t=%0t: got %h, expected %h", nm, i, $time, act, exp);
      end
   endtask

   task automatic fail(string nm, int i);
      n_vec++;
      n_err++;
      $display("FAIL %s dut%0d t=%0t: timed out", nm, i, $time);
   endtask

   // Monitor: records accepts into the scoreboard, checks latency, ready and results
   always @(negedge clk) begin
      logic [20:0] e;
      if (rst_n) begin
         for (int i = 0; i < 3; i++) begin
            chk("in_ready", i, 32'(irdy[i]), 32'(!busy[i]));
            if (iv[i] && irdy[i]) begin
               qpush(i, model(i, idat[i]));
               acc_cyc[i] = cyc;
               busy[i] = 1'b1;
            end
            if (ovld[i] && !ovld_q[i]) begin
               chk("latency", i, 32'(cyc - acc_cyc[i]), 32'(W[i] + 1));
            end
            if (ovld[i] && ordy[i]) begin
               if (qsize(i) == 0) begin
                  fail("unexpected_result", i);
               end else begin
                  e = qpop(i);
                  chk("out_bcd", i, 32'(obcd[i]), 32'(e[19:0]));
                  chk("out_neg", i, 32'(oneg[i]), 32'(e[20]));
               end
               busy[i] = 1'b0;
            end
            ovld_q[i] = ovld[i];
         end
      end
   end

   // Random backpressure during the randomized phase
   always begin
      @(posedge clk);
      #1;
      if (rnd_mode) ordy = 3'($urandom_range(0, 7) | $urandom_range(0, 7));
   end

   // Present an operand until it is accepted; called and returns at posedge+1
   task automatic send(int i, logic [15:0] d);
      int t;
      bit acc;
      t = 0;
      acc = 1'b0;
      iv[i] = 1'b1;
      idat[i] = d;
      while (!acc && t < 300) begin
         @(negedge clk);
         acc = irdy[i] && rst_n;
         @(posedge clk);
         #1;
         t++;
      end
      iv[i] = 1'b0;
      idat[i] = 16'($urandom);
      if (!acc) fail("accept_timeout", i);
   endtask

   task automatic wait_idle(int i);
      int t;
      t = 0;
      while ((qsize(i) != 0 || ovld[i]) && t < 2000) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 2000) fail("drain_timeout", i);
   endtask

   task automatic rnd_drive(int i, int n);
      logic [15:0] d;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         d = 16'($urandom);
         case ($urandom_range(0, 15))
            0: d = '0;
            1: d = 16'((32'd1 << W[i]) - 1);
            2: d = 16'(32'd1 << (W[i] - 1));
            default: ;
         endcase
         send(i, d);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog t=%0t: simulation did not finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_in_ready", i, 32'(irdy[i]), 32'd1);
         chk("rst_out_valid", i, 32'(ovld[i]), 32'd0);
         chk("rst_out_bcd", i, 32'(obcd[i]), 32'd0);
         chk("rst_out_neg", i, 32'(oneg[i]), 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 8-bit unsigned directed values, out_ready held high
      send(0, 16'd0);
      send(0, 16'd9);
      send(0, 16'd10);
      send(0, 16'd99);
      send(0, 16'd100);
      send(0, 16'd255);
      wait_idle(0);

      // Backpressure: result must hold while in_valid is ignored
      ordy[0] = 1'b0;
      send(0, 16'd173);
      iv[0] = 1'b1;
      idat[0] = 16'd42;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!ovld[0] && t < 50);
      if (!ovld[0]) fail("bp_out_valid", 0);
      repeat (6) begin
         chk("bp_hold_bcd", 0, 32'(obcd[0]), 32'h173);
         chk("bp_hold_ready", 0, 32'(irdy[0]), 32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      ordy[0] = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!irdy[0] && t < 50);
      if (!irdy[0]) fail("bp_reaccept", 0);
      @(posedge clk);
      #1;
      iv[0] = 1'b0;
      wait_idle(0);
      chk("bp_result_42", 0, 32'(obcd[0]), 32'h042);

      // 16-bit unsigned
      send(1, 16'd65535);
      send(1, 16'd10000);
      send(1, 16'd1);
      wait_idle(1);

      // 8-bit signed
      send(2, 16'h80);
      send(2, 16'hFF);
      send(2, 16'h7F);
      send(2, 16'h00);
      wait_idle(2);

      // Asynchronous reset in the middle of converting 200
      send(0, 16'd200);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", 0, 32'(irdy[0]), 32'd1);
      chk("midrst_out_valid", 0, 32'(ovld[0]), 32'd0);
      chk("midrst_out_bcd", 0, 32'(obcd[0]), 32'd0);
      chk("midrst_out_neg", 0, 32'(oneg[0]), 32'd0);
      q0.delete();
      busy[0] = 1'b0;
      ovld_q[0] = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(0, 16'd57);
      wait_idle(0);
      chk("post_rst_57", 0, 32'(obcd[0]), 32'h057);

      // Randomized traffic on all three instances at once
      rnd_mode = 1;
      fork
         rnd_drive(0, 1000);
         rnd_drive(1, 1000);
         rnd_drive(2, 1000);
      join
      rnd_mode = 0;
      @(posedge clk);
      #2;
      ordy = '1;
      for (int i = 0; i < 3; i++) wait_idle(i);
      repeat (2) @(posedge clk);
      for (int i = 0; i < 3; i++) chk("queue_empty", i, 32'(qsize(i)), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
